// File: rtl/ysyx_040066_dmem_pkg.sv
// Shared types and constants for the data-memory bridge.
// Optional bus timeout is enabled with DMEM_TIMEOUT_EN.
package ysyx_040066_dmem_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_D,
        S_WR_AW,
        S_WR_B,
        S_DONE
    } state_e;

    localparam logic [2:0] SZ_B = 3'd0;
    localparam logic [2:0] SZ_H = 3'd1;
    localparam logic [2:0] SZ_W = 3'd2;
    localparam logic [2:0] SZ_D = 3'd3;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam int TIMEOUT_DEF = 255;

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] size_mask(input logic [1:0] sz);
        logic [2:0] m;
        m = 3'b111;
        unique case (sz)
            2'd0: m = 3'b000;
            2'd1: m = 3'b001;
            2'd2: m = 3'b011;
            2'd3: m = 3'b111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ysyx_040066_dmem_chk.sv
// Combinational legality check for a core data request.
// Flags conflict, bad size, misalignment and out-of-range address.
module ysyx_040066_dmem_chk
    import ysyx_040066_dmem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic        rd_i,
    input  logic        wr_i,
    input  logic [63:0] addr_i,
    input  logic [2:0]  len_i,
    output logic        illegal_o
);

    logic conflict;
    logic bad_size;
    logic misalign;
    logic out_range;

    assign conflict  = rd_i & wr_i;
    assign bad_size  = len_i > SZ_D;
    assign misalign  = !bad_size &&
                       ((addr_i[2:0] & size_mask(len_i[1:0])) != 3'b000);
    assign out_range = (addr_i >> ADDR_W) != 64'd0;

    assign illegal_o = conflict | bad_size | misalign | out_range;

endmodule

// File: rtl/ysyx_040066_dmem_bridge.sv
// Core data port to single-beat AXI4-Lite-style bus bridge.
// Define DMEM_TIMEOUT_EN to bound each bus phase by TIMEOUT cycles.
module ysyx_040066_dmem_bridge
    import ysyx_040066_dmem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRd,
    input  logic              MemWr,
    input  logic [63:0]       addr,
    input  logic [2:0]        wr_len,
    input  logic [7:0]        wr_mask,
    input  logic [63:0]       data_Wr,
    output logic [63:0]       data_Rd,
    output logic              data_valid,
    output logic              data_error,
    output logic              ar_valid,
    input  logic              ar_ready,
    output logic [ADDR_W-1:0] ar_addr,
    output logic [2:0]        ar_size,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [63:0]       r_data,
    input  logic [1:0]        r_resp,
    output logic              aw_valid,
    input  logic              aw_ready,
    output logic [ADDR_W-1:0] aw_addr,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [63:0]       w_data,
    output logic [7:0]        w_strb,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [1:0]        b_resp
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        size_q, size_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [7:0]        strb_q, strb_d;
    logic [63:0]       rdata_q, rdata_d;
    logic              ar_valid_q, ar_valid_d;
    logic              r_ready_q, r_ready_d;
    logic              aw_valid_q, aw_valid_d;
    logic              w_valid_q, w_valid_d;
    logic              b_ready_q, b_ready_d;
    logic              aw_sent_q, aw_sent_d;
    logic              w_sent_q, w_sent_d;
    logic              dv_q, dv_d;
    logic              derr_q, derr_d;

    logic illegal;
    logic aw_done;
    logic w_done;
    logic tmo;

    ysyx_040066_dmem_chk #(
        .ADDR_W (ADDR_W)
    ) u_chk (
        .rd_i      (MemRd),
        .wr_i      (MemWr),
        .addr_i    (addr),
        .len_i     (wr_len),
        .illegal_o (illegal)
    );

    assign aw_done = aw_sent_q | (aw_valid_q & aw_ready);
    assign w_done  = w_sent_q | (w_valid_q & w_ready);

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ?
                           $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy;

    assign busy = (state_q == S_RD_A) || (state_q == S_RD_D) ||
                  (state_q == S_WR_AW) || (state_q == S_WR_B);
    assign tmo  = busy && (cnt_q == CNT_W'(TIMEOUT));

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (busy) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        rdata_d    = rdata_q;
        ar_valid_d = ar_valid_q;
        r_ready_d  = r_ready_q;
        aw_valid_d = aw_valid_q;
        w_valid_d  = w_valid_q;
        b_ready_d  = b_ready_q;
        aw_sent_d  = aw_sent_q;
        w_sent_d   = w_sent_q;
        dv_d       = 1'b0;
        derr_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (MemRd || MemWr) begin
                    addr_d  = {addr[ADDR_W-1:3], 3'b000};
                    size_d  = wr_len;
                    wdata_d = data_Wr;
                    strb_d  = wr_mask;
                    if (illegal) begin
                        state_d = S_DONE;
                        dv_d    = 1'b1;
                        derr_d  = 1'b1;
                    end else if (MemRd) begin
                        state_d    = S_RD_A;
                        ar_valid_d = 1'b1;
                    end else begin
                        state_d    = S_WR_AW;
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                        aw_sent_d  = 1'b0;
                        w_sent_d   = 1'b0;
                    end
                end
            end
            S_RD_A: begin
                if (ar_ready) begin
                    state_d    = S_RD_D;
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                end
            end
            S_RD_D: begin
                if (r_valid) begin
                    state_d   = S_DONE;
                    r_ready_d = 1'b0;
                    rdata_d   = r_data;
                    dv_d      = 1'b1;
                    derr_d    = r_resp != RESP_OKAY;
                end
            end
            S_WR_AW: begin
                if (aw_valid_q && aw_ready) begin
                    aw_valid_d = 1'b0;
                    aw_sent_d  = 1'b1;
                end
                if (w_valid_q && w_ready) begin
                    w_valid_d = 1'b0;
                    w_sent_d  = 1'b1;
                end
                if (aw_done && w_done) begin
                    state_d   = S_WR_B;
                    b_ready_d = 1'b1;
                end
            end
            S_WR_B: begin
                if (b_valid) begin
                    state_d   = S_DONE;
                    b_ready_d = 1'b0;
                    dv_d      = 1'b1;
                    derr_d    = b_resp != RESP_OKAY;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A stuck phase abandons the transaction; late responses are ignored.
        if (tmo) begin
            state_d    = S_DONE;
            ar_valid_d = 1'b0;
            r_ready_d  = 1'b0;
            aw_valid_d = 1'b0;
            w_valid_d  = 1'b0;
            b_ready_d  = 1'b0;
            dv_d       = 1'b1;
            derr_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            wdata_q    <= '0;
            strb_q     <= '0;
            rdata_q    <= '0;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            aw_sent_q  <= 1'b0;
            w_sent_q   <= 1'b0;
            dv_q       <= 1'b0;
            derr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            wdata_q    <= wdata_d;
            strb_q     <= strb_d;
            rdata_q    <= rdata_d;
            ar_valid_q <= ar_valid_d;
            r_ready_q  <= r_ready_d;
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            b_ready_q  <= b_ready_d;
            aw_sent_q  <= aw_sent_d;
            w_sent_q   <= w_sent_d;
            dv_q       <= dv_d;
            derr_q     <= derr_d;
        end
    end

    assign data_Rd    = rdata_q;
    assign data_valid = dv_q;
    assign data_error = derr_q;
    assign ar_valid   = ar_valid_q;
    assign ar_addr    = addr_q;
    assign ar_size    = size_q;
    assign r_ready    = r_ready_q;
    assign aw_valid   = aw_valid_q;
    assign aw_addr    = addr_q;
    assign w_valid    = w_valid_q;
    assign w_data     = wdata_q;
    assign w_strb     = strb_q;
    assign b_ready    = b_ready_q;

endmodule

// File: tb/tb_ysyx_040066_dmem_bridge.sv
// Directed self-checking bench for the data-memory bridge.
// Timeout scenario runs only when DMEM_TIMEOUT_EN is defined.
module tb_ysyx_040066_dmem_bridge;

    logic        clk;
    logic        rst;
    logic        MemRd;
    logic        MemWr;
    logic [63:0] addr;
    logic [2:0]  wr_len;
    logic [7:0]  wr_mask;
    logic [63:0] data_Wr;
    logic [63:0] data_Rd;
    logic        data_valid;
    logic        data_error;
    logic        ar_valid;
    logic        ar_ready;
    logic [31:0] ar_addr;
    logic [2:0]  ar_size;
    logic        r_valid;
    logic        r_ready;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        aw_valid;
    logic        aw_ready;
    logic [31:0] aw_addr;
    logic        w_valid;
    logic        w_ready;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        b_valid;
    logic        b_ready;
    logic [1:0]  b_resp;

    int passed = 0;
    int total  = 0;

    ysyx_040066_dmem_bridge #(
        .ADDR_W  (32),
        .TIMEOUT (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .MemRd      (MemRd),
        .MemWr      (MemWr),
        .addr       (addr),
        .wr_len     (wr_len),
        .wr_mask    (wr_mask),
        .data_Wr    (data_Wr),
        .data_Rd    (data_Rd),
        .data_valid (data_valid),
        .data_error (data_error),
        .ar_valid   (ar_valid),
        .ar_ready   (ar_ready),
        .ar_addr    (ar_addr),
        .ar_size    (ar_size),
        .r_valid    (r_valid),
        .r_ready    (r_ready),
        .r_data     (r_data),
        .r_resp     (r_resp),
        .aw_valid   (aw_valid),
        .aw_ready   (aw_ready),
        .aw_addr    (aw_addr),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .w_data     (w_data),
        .w_strb     (w_strb),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_resp     (b_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_idle_bus(input string tag);
        chk({tag, "_ar"}, 64'(ar_valid), 64'd0);
        chk({tag, "_aw"}, 64'(aw_valid), 64'd0);
        chk({tag, "_w"},  64'(w_valid),  64'd0);
    endtask

    initial begin
        rst = 1'b1;
        MemRd = 1'b0; MemWr = 1'b0;
        addr = '0; wr_len = '0; wr_mask = '0; data_Wr = '0;
        ar_ready = 1'b1; r_valid = 1'b0; r_data = '0; r_resp = 2'b00;
        aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b0; b_resp = 2'b00;
        tick();
        tick();
        chk("rst_dv", 64'(data_valid), 64'd0);
        chk("rst_de", 64'(data_error), 64'd0);
        chk("rst_rr", 64'(r_ready), 64'd0);
        chk("rst_br", 64'(b_ready), 64'd0);
        chk("rst_rd", data_Rd, 64'd0);
        chk_idle_bus("rst");
        rst = 1'b0;

        // Zero-wait read.
        MemRd = 1'b1; addr = 64'h8000_0010; wr_len = 3'd3;
        tick();
        chk("rd_arv", 64'(ar_valid), 64'd1);
        chk("rd_ara", 64'(ar_addr), 64'h8000_0010);
        chk("rd_ars", 64'(ar_size), 64'd3);
        chk("rd_dv1", 64'(data_valid), 64'd0);
        tick();
        chk("rd_arv2", 64'(ar_valid), 64'd0);
        chk("rd_rr", 64'(r_ready), 64'd1);
        r_valid = 1'b1; r_data = 64'h1122_3344_5566_7788;
        tick();
        chk("rd_dv", 64'(data_valid), 64'd1);
        chk("rd_de", 64'(data_error), 64'd0);
        chk("rd_data", data_Rd, 64'h1122_3344_5566_7788);
        chk("rd_rr2", 64'(r_ready), 64'd0);
        MemRd = 1'b0; r_valid = 1'b0; r_data = '0;
        tick();
        chk("rd_dv_end", 64'(data_valid), 64'd0);

        // Write with aw_ready held off for four cycles.
        MemWr = 1'b1; addr = 64'h8000_0006; wr_len = 3'd1;
        wr_mask = 8'hC0; data_Wr = 64'hABCD_0000_0000_0000;
        aw_ready = 1'b0; w_ready = 1'b1;
        tick();
        chk("wr_awv", 64'(aw_valid), 64'd1);
        chk("wr_wv", 64'(w_valid), 64'd1);
        chk("wr_awa", 64'(aw_addr), 64'h8000_0000);
        chk("wr_strb", 64'(w_strb), 64'hC0);
        chk("wr_wdata", w_data, 64'hABCD_0000_0000_0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wr_stall_awv", 64'(aw_valid), 64'd1);
            chk("wr_stall_wv", 64'(w_valid), 64'd0);
            chk("wr_stall_awa", 64'(aw_addr), 64'h8000_0000);
            chk("wr_stall_br", 64'(b_ready), 64'd0);
            chk("wr_stall_dv", 64'(data_valid), 64'd0);
        end
        aw_ready = 1'b1;
        tick();
        chk("wr_awv2", 64'(aw_valid), 64'd0);
        chk("wr_br", 64'(b_ready), 64'd1);
        b_valid = 1'b1; b_resp = 2'b00;
        tick();
        chk("wr_dv", 64'(data_valid), 64'd1);
        chk("wr_de", 64'(data_error), 64'd0);
        chk("wr_br2", 64'(b_ready), 64'd0);
        MemWr = 1'b0; b_valid = 1'b0;
        tick();
        chk("wr_dv_once", 64'(data_valid), 64'd0);

        // Misaligned word read.
        MemRd = 1'b1; addr = 64'h8000_0003; wr_len = 3'd2;
        tick();
        chk("il_al_dv", 64'(data_valid), 64'd1);
        chk("il_al_de", 64'(data_error), 64'd1);
        chk_idle_bus("il_al");
        // Read and write together, issued in the cycle after DONE.
        MemRd = 1'b1; MemWr = 1'b1; addr = 64'h8000_0000; wr_len = 3'd3;
        tick();
        chk("il_rw_dv", 64'(data_valid), 64'd0);
        tick();
        chk("il_rw_dv2", 64'(data_valid), 64'd1);
        chk("il_rw_de", 64'(data_error), 64'd1);
        chk_idle_bus("il_rw");
        // Address above the 32-bit window.
        MemWr = 1'b0; addr = 64'h1_0000_0000;
        tick();
        tick();
        chk("il_rg_dv", 64'(data_valid), 64'd1);
        chk("il_rg_de", 64'(data_error), 64'd1);
        chk_idle_bus("il_rg");
        // Illegal size code.
        addr = 64'h8000_0000; wr_len = 3'd5;
        tick();
        tick();
        chk("il_sz_dv", 64'(data_valid), 64'd1);
        chk("il_sz_de", 64'(data_error), 64'd1);
        MemRd = 1'b0;
        tick();

        // Write answered with SLVERR.
        MemWr = 1'b1; addr = 64'h8000_0008; wr_len = 3'd3;
        wr_mask = 8'hFF; data_Wr = 64'h0123_4567_89AB_CDEF;
        tick();
        chk("be_awv", 64'(aw_valid), 64'd1);
        chk("be_wv", 64'(w_valid), 64'd1);
        tick();
        chk("be_br", 64'(b_ready), 64'd1);
        b_valid = 1'b1; b_resp = 2'b10;
        tick();
        chk("be_dv", 64'(data_valid), 64'd1);
        chk("be_de", 64'(data_error), 64'd1);
        chk("be_rd_hold", data_Rd, 64'h1122_3344_5566_7788);
        MemWr = 1'b0; b_valid = 1'b0; b_resp = 2'b00;
        tick();
        // Immediate follow-up read.
        MemRd = 1'b1; addr = 64'h8000_0024; wr_len = 3'd2;
        tick();
        chk("be_rd_arv", 64'(ar_valid), 64'd1);
        chk("be_rd_ara", 64'(ar_addr), 64'h8000_0020);
        chk("be_rd_ars", 64'(ar_size), 64'd2);
        tick();
        r_valid = 1'b1; r_data = 64'hDEAD_BEEF_CAFE_F00D; r_resp = 2'b00;
        tick();
        chk("be_rd_dv", 64'(data_valid), 64'd1);
        chk("be_rd_de", 64'(data_error), 64'd0);
        chk("be_rd_data", data_Rd, 64'hDEAD_BEEF_CAFE_F00D);
        MemRd = 1'b0; r_valid = 1'b0;
        tick();

        // Read completing with an error response.
        MemRd = 1'b1; addr = 64'h8000_0030; wr_len = 3'd0;
        tick();
        tick();
        r_valid = 1'b1; r_data = 64'h5555_AAAA_5555_AAAA; r_resp = 2'b11;
        tick();
        chk("re_dv", 64'(data_valid), 64'd1);
        chk("re_de", 64'(data_error), 64'd1);
        MemRd = 1'b0; r_valid = 1'b0; r_resp = 2'b00;
        tick();

        // Reset while waiting for read data.
        MemRd = 1'b1; addr = 64'h8000_0040; wr_len = 3'd3;
        tick();
        tick();
        chk("mr_rr", 64'(r_ready), 64'd1);
        rst = 1'b1;
        tick();
        chk("mr_rr0", 64'(r_ready), 64'd0);
        chk("mr_dv0", 64'(data_valid), 64'd0);
        chk("mr_de0", 64'(data_error), 64'd0);
        chk("mr_br0", 64'(b_ready), 64'd0);
        chk("mr_rd0", data_Rd, 64'd0);
        chk_idle_bus("mr");
        rst = 1'b0;
        tick();
        chk("mr_arv", 64'(ar_valid), 64'd1);
        chk("mr_ara", 64'(ar_addr), 64'h8000_0040);
        tick();
        r_valid = 1'b1; r_data = 64'h0F0E_0D0C_0B0A_0908;
        tick();
        chk("mr_dv", 64'(data_valid), 64'd1);
        chk("mr_de", 64'(data_error), 64'd0);
        chk("mr_data", data_Rd, 64'h0F0E_0D0C_0B0A_0908);
        MemRd = 1'b0; r_valid = 1'b0;
        tick();

`ifdef DMEM_TIMEOUT_EN
        // Address phase that never completes.
        ar_ready = 1'b0;
        MemRd = 1'b1; addr = 64'h8000_0050; wr_len = 3'd3;
        tick();
        chk("to_arv", 64'(ar_valid), 64'd1);
        for (int i = 1; i < 9; i++) begin
            tick();
            chk("to_wait_arv", 64'(ar_valid), 64'd1);
            chk("to_wait_dv", 64'(data_valid), 64'd0);
        end
        tick();
        chk("to_dv", 64'(data_valid), 64'd1);
        chk("to_de", 64'(data_error), 64'd1);
        chk("to_arv0", 64'(ar_valid), 64'd0);
        MemRd = 1'b0; ar_ready = 1'b1;
        tick();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
